// File: rtl/sd_step_ctl.sv
// sd_step_ctl: run/halt/single-step controller for a stepped stream channel.
// Drives the shim's enable and step request, tracks how many transfers are
// still owed for the current step, and can halt the channel on a data match.
module sd_step_ctl #(
    parameter int width = 32,
    parameter int cntw  = 16,
    parameter int gap   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_srdy,
    output logic              cmd_drdy,
    input  logic [1:0]        cmd_op,
    input  logic [cntw-1:0]   cmd_count,
    input  logic [width-1:0]  cmd_data,
    input  logic [width-1:0]  cmd_mask,
    input  logic              mon_srdy,
    input  logic              mon_drdy,
    input  logic [width-1:0]  mon_data,
    output logic              cfg_en,
    output logic              cfg_step,
    output logic [1:0]        stat_state,
    output logic [cntw-1:0]   stat_remaining,
    output logic [cntw-1:0]   stat_xfer_cnt,
    output logic              break_hit,
    output logic              cmd_err
);

    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_HALT = 2'b01;
    localparam logic [1:0] S_HI   = 2'b10;
    localparam logic [1:0] S_WAIT = 2'b11;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_ARM  = 2'b11;

    // Wait counter is 8 bits: the timeout never exceeds 255 cycles.
    localparam logic [7:0] GAP_CNT = 8'(gap);

    logic [1:0]        r_state;
    logic              r_hi;
    logic [7:0]        r_wait;
    logic [cntw-1:0]   r_rem;
    logic [cntw-1:0]   r_xfer;
    logic              r_armed;
    logic [width-1:0]  r_match;
    logic [width-1:0]  r_mask;
    logic              r_en;
    logic              r_step;
    logic              r_brk;
    logic              r_err;
    logic              r_drdy;

    logic              w_cmd;
    logic              w_xfer;
    logic              w_match;
    logic [cntw-1:0]   w_rem_dec;
    logic [1:0]        w_state_nx;
    logic              w_hi_nx;
    logic [7:0]        w_wait_nx;
    logic [cntw-1:0]   w_rem_nx;
    logic              w_armed_nx;
    logic              w_arm_ld;
    logic              w_brk_nx;
    logic              w_err_nx;

    assign w_cmd   = cmd_srdy && r_drdy;
    assign w_xfer  = mon_srdy && mon_drdy;
    assign w_match = r_armed && (r_state == S_RUN) && w_xfer &&
                     (((mon_data ^ r_match) & r_mask) == '0);
    // Remaining only counts down while stepping and never underflows.
    assign w_rem_dec = (w_xfer && (r_rem != '0)) ? (r_rem - cntw'(1)) : r_rem;

    // Next-state and counter updates; a break match pre-empts any command.
    always_comb begin
        w_state_nx = r_state;
        w_hi_nx    = r_hi;
        w_wait_nx  = r_wait;
        w_rem_nx   = r_rem;
        w_armed_nx = r_armed;
        w_arm_ld   = 1'b0;
        w_brk_nx   = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_match) begin
                    w_state_nx = S_HALT;
                    w_brk_nx   = 1'b1;
                    w_armed_nx = 1'b0;
                end else if (w_cmd) begin
                    case (cmd_op)
                        OP_HALT: w_state_nx = S_HALT;
                        OP_STEP: begin
                            if (cmd_count != '0) begin
                                w_state_nx = S_HI;
                                w_rem_nx   = cmd_count;
                                w_hi_nx    = 1'b0;
                            end else begin
                                w_state_nx = S_HALT;
                            end
                        end
                        OP_ARM: begin
                            w_arm_ld   = 1'b1;
                            w_armed_nx = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT: begin
                if (w_cmd) begin
                    case (cmd_op)
                        OP_RUN: w_state_nx = S_RUN;
                        OP_STEP: begin
                            if (cmd_count != '0) begin
                                w_state_nx = S_HI;
                                w_rem_nx   = cmd_count;
                                w_hi_nx    = 1'b0;
                            end
                        end
                        OP_ARM: begin
                            w_arm_ld   = 1'b1;
                            w_armed_nx = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_HI: begin
                // Step request is held high for two cycles so the shim sees a clean edge.
                w_rem_nx = w_rem_dec;
                if (r_hi) begin
                    w_state_nx = S_WAIT;
                    w_wait_nx  = GAP_CNT;
                end else begin
                    w_hi_nx = 1'b1;
                end
                if (w_cmd) begin
                    if (cmd_op == OP_HALT) begin
                        w_state_nx = S_HALT;
                        w_rem_nx   = '0;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
            end
            default: begin
                // S_WAIT: finish when the owed transfers are seen, else re-pulse on timeout.
                w_rem_nx  = w_rem_dec;
                w_wait_nx = (r_wait != 8'd0) ? (r_wait - 8'd1) : 8'd0;
                if (w_rem_dec == '0) begin
                    w_state_nx = S_HALT;
                end else if (r_wait <= 8'd1) begin
                    w_state_nx = S_HI;
                    w_hi_nx    = 1'b0;
                end
                if (w_cmd) begin
                    if (cmd_op == OP_HALT) begin
                        w_state_nx = S_HALT;
                        w_rem_nx   = '0;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
            end
        endcase
    end

    // Control state, counters and registered shim outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_hi    <= 1'b0;
            r_wait  <= 8'd0;
            r_rem   <= '0;
            r_xfer  <= '0;
            r_armed <= 1'b0;
            r_en    <= 1'b0;
            r_step  <= 1'b0;
            r_brk   <= 1'b0;
            r_err   <= 1'b0;
            r_drdy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_hi    <= w_hi_nx;
            r_wait  <= w_wait_nx;
            r_rem   <= w_rem_nx;
            r_armed <= w_armed_nx;
            r_en    <= (w_state_nx != S_RUN);
            r_step  <= (w_state_nx == S_HI);
            r_brk   <= w_brk_nx;
            r_err   <= w_err_nx;
            r_drdy  <= 1'b1;
            if (w_xfer) begin
                r_xfer <= r_xfer + cntw'(1);
            end
        end
    end

    // Break match value and mask; only meaningful while armed.
    always_ff @(posedge clk) begin
        if (w_arm_ld) begin
            r_match <= cmd_data;
            r_mask  <= cmd_mask;
        end
    end

    assign cmd_drdy       = r_drdy;
    assign cfg_en         = r_en;
    assign cfg_step       = r_step;
    assign stat_state     = r_state;
    assign stat_remaining = r_rem;
    assign stat_xfer_cnt  = r_xfer;
    assign break_hit      = r_brk;
    assign cmd_err        = r_err;

endmodule

// File: tb/tb_sd_step_ctl.sv
// tb_sd_step_ctl: self-checking bench for sd_step_ctl with a transfer-count
// scoreboard and a simple shim model that releases one beat per step edge.
module tb_sd_step_ctl;

    localparam int W = 32;
    localparam int C = 16;
    localparam int G = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_srdy = 1'b0;
    logic          cmd_drdy;
    logic [1:0]    cmd_op = 2'b00;
    logic [C-1:0]  cmd_count = '0;
    logic [W-1:0]  cmd_data = '0;
    logic [W-1:0]  cmd_mask = '0;
    logic          mon_srdy = 1'b0;
    logic          mon_drdy = 1'b1;
    logic [W-1:0]  mon_data = '0;
    logic          cfg_en;
    logic          cfg_step;
    logic [1:0]    stat_state;
    logic [C-1:0]  stat_remaining;
    logic [C-1:0]  stat_xfer_cnt;
    logic          break_hit;
    logic          cmd_err;

    always #5 clk = ~clk;

    sd_step_ctl #(.width(W), .cntw(C), .gap(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_srdy(cmd_srdy), .cmd_drdy(cmd_drdy), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .mon_srdy(mon_srdy), .mon_drdy(mon_drdy), .mon_data(mon_data),
        .cfg_en(cfg_en), .cfg_step(cfg_step), .stat_state(stat_state),
        .stat_remaining(stat_remaining), .stat_xfer_cnt(stat_xfer_cnt),
        .break_hit(break_hit), .cmd_err(cmd_err)
    );

    int           n_chk = 0;
    int           n_err = 0;
    logic [31:0]  sb_q[$];
    int           tb_cnt = 0;
    bit           sb_en = 1'b1;
    int           cyc_n = 0;
    int           step_edges = 0;
    int           shim_seen = 0;
    int           last_edge_cyc = 0;
    int           edge_gap = 0;
    logic         step_prev = 1'b0;
    int           base;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: drive the monitor tap, advance to the next falling edge,
    // track step edges and retire any scoreboard entry for this beat.
    task automatic tick(input logic srdy, input logic drdy, input logic [W-1:0] data);
        logic xf;
        logic [31:0] exp;
        mon_srdy = srdy;
        mon_drdy = drdy;
        mon_data = data;
        xf = srdy && drdy && rst_n;
        if (xf) begin
            tb_cnt = tb_cnt + 1;
            if (sb_en) sb_q.push_back(32'(tb_cnt & 32'hFFFF));
        end
        @(negedge clk);
        cyc_n++;
        if (cfg_step && !step_prev) begin
            if (step_edges > 0) edge_gap = cyc_n - last_edge_cyc;
            last_edge_cyc = cyc_n;
            step_edges++;
        end
        step_prev = cfg_step;
        if (xf && sb_en) begin
            exp = sb_q.pop_front();
            chk("xfer_cnt", 32'(stat_xfer_cnt), exp);
        end
        mon_srdy = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [C-1:0] cnt,
                        input logic [W-1:0] d, input logic [W-1:0] m);
        cmd_srdy = 1'b1; cmd_op = op; cmd_count = cnt; cmd_data = d; cmd_mask = m;
        tick(1'b0, 1'b1, '0);
        cmd_srdy = 1'b0;
    endtask

    task automatic clr_edges();
        step_edges = 0;
        shim_seen = 0;
        edge_gap = 0;
    endtask

    // Shim model: after each observed step edge, one beat passes if traffic is on.
    task automatic shim(input int n, input logic traffic);
        logic pend;
        for (int i = 0; i < n; i++) begin
            pend = (step_edges != shim_seen);
            shim_seen = step_edges;
            tick(traffic && pend, 1'b1, 32'(i + 32'h100));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_srdy = 1'b0;
        mon_srdy = 1'b0;
        repeat (2) @(negedge clk);
        tb_cnt = 0;
        sb_q.delete();
        step_prev = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset values while held in reset
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(stat_state), 0);
        chk("rst_cfg_en", 32'(cfg_en), 0);
        chk("rst_cfg_step", 32'(cfg_step), 0);
        chk("rst_rem", 32'(stat_remaining), 0);
        chk("rst_xfer", 32'(stat_xfer_cnt), 0);
        chk("rst_brk", 32'(break_hit), 0);
        chk("rst_err", 32'(cmd_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("drdy_after_rst", 32'(cmd_drdy), 1);

        // Ten beats in RUN, plus one stalled beat that must not count
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 32'(i));
        tick(1'b1, 1'b0, 32'h55);
        chk("run_xfer10", 32'(stat_xfer_cnt), 10);
        chk("run_cfg_en", 32'(cfg_en), 0);
        chk("run_state", 32'(stat_state), 0);

        // STEP with zero count from RUN halts; from HALT it is ignored
        send(2'b10, 16'd0, '0, '0);
        chk("step0_run_state", 32'(stat_state), 1);
        chk("step0_run_en", 32'(cfg_en), 1);
        send(2'b10, 16'd0, '0, '0);
        tick(1'b0, 1'b1, '0);
        chk("step0_halt_state", 32'(stat_state), 1);
        chk("step0_halt_step", 32'(cfg_step), 0);

        // STEP 3 with the downstream always ready
        base = 32'(stat_xfer_cnt);
        clr_edges();
        send(2'b10, 16'd3, '0, '0);
        chk("step3_hi_state", 32'(stat_state), 2);
        shim(40, 1'b1);
        chk("step3_edges", step_edges, 3);
        chk("step3_xfers", 32'(stat_xfer_cnt), 32'(base + 3));
        chk("step3_state", 32'(stat_state), 1);
        chk("step3_rem", 32'(stat_remaining), 0);
        chk("step3_cfg_step", 32'(cfg_step), 0);

        // STEP 2 with no traffic: periodic re-pulse, then completion
        clr_edges();
        send(2'b10, 16'd2, '0, '0);
        shim(20, 1'b0);
        chk("stall_edges", step_edges, 3);
        chk("stall_period", edge_gap, 8);
        chk("stall_rem", 32'(stat_remaining), 2);
        shim(30, 1'b1);
        chk("resume_edges", step_edges, 5);
        chk("resume_state", 32'(stat_state), 1);
        chk("resume_rem", 32'(stat_remaining), 0);

        // STEP 5: a STEP mid-step is dropped, then HALT aborts
        send(2'b10, 16'd5, '0, '0);
        repeat (3) tick(1'b0, 1'b1, '0);
        chk("mid_wait_state", 32'(stat_state), 3);
        send(2'b10, 16'd7, '0, '0);
        chk("mid_err_pulse", 32'(cmd_err), 1);
        chk("mid_err_state", 32'(stat_state), 3);
        chk("mid_err_rem", 32'(stat_remaining), 5);
        send(2'b01, 16'd0, '0, '0);
        chk("mid_err_clear", 32'(cmd_err), 0);
        chk("abort_state", 32'(stat_state), 1);
        chk("abort_rem", 32'(stat_remaining), 0);
        chk("abort_en", 32'(cfg_en), 1);

        // Break on the masked match, then the arm is spent
        send(2'b00, 16'd0, '0, '0);
        send(2'b11, 16'd0, 32'h0000_00A5, 32'h0000_00FF);
        tick(1'b1, 1'b1, 32'h11);
        chk("brk_no_11", 32'(break_hit), 0);
        tick(1'b1, 1'b1, 32'h22);
        chk("brk_no_22", 32'(break_hit), 0);
        tick(1'b1, 1'b1, 32'h1A5);
        chk("brk_hit", 32'(break_hit), 1);
        chk("brk_state", 32'(stat_state), 1);
        tick(1'b0, 1'b1, '0);
        chk("brk_pulse_end", 32'(break_hit), 0);
        send(2'b00, 16'd0, '0, '0);
        tick(1'b1, 1'b1, 32'hA5);
        chk("disarmed_brk", 32'(break_hit), 0);
        chk("disarmed_state", 32'(stat_state), 0);

        // Break beats a same-cycle STEP
        send(2'b11, 16'd0, 32'h0000_00A5, 32'h0000_00FF);
        cmd_srdy = 1'b1; cmd_op = 2'b10; cmd_count = 16'd4;
        tick(1'b1, 1'b1, 32'hFFFF_FFA5);
        cmd_srdy = 1'b0;
        chk("prio_brk", 32'(break_hit), 1);
        chk("prio_state", 32'(stat_state), 1);
        chk("prio_step", 32'(cfg_step), 0);

        // Armed in HALT: no match until back in RUN
        send(2'b11, 16'd0, 32'h0000_003C, 32'h0000_00FF);
        tick(1'b1, 1'b1, 32'h3C);
        chk("halt_nomatch", 32'(break_hit), 0);
        send(2'b00, 16'd0, '0, '0);
        tick(1'b1, 1'b1, 32'h3C);
        chk("run_match", 32'(break_hit), 1);

        // Transfer counter wraps
        do_reset();
        sb_en = 1'b0;
        for (int i = 0; i < 65535; i++) tick(1'b1, 1'b1, '0);
        chk("near_wrap", 32'(stat_xfer_cnt), 32'hFFFF);
        sb_en = 1'b1;
        tick(1'b1, 1'b1, '0);
        tick(1'b1, 1'b1, '0);
        chk("wrap_to_1", 32'(stat_xfer_cnt), 1);

        // Reset asserted during STEP_HI
        send(2'b01, 16'd0, '0, '0);
        send(2'b10, 16'd3, '0, '0);
        chk("pre_rst_step", 32'(cfg_step), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_step", 32'(cfg_step), 0);
        chk("async_rst_state", 32'(stat_state), 0);
        chk("async_rst_en", 32'(cfg_en), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step_prev = 1'b0;
        clr_edges();
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, '0);
        chk("post_rst_edges", step_edges, 0);
        chk("post_rst_state", 32'(stat_state), 0);
        chk("post_rst_drdy", 32'(cmd_drdy), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sd_step_ctl.md
SD_STEP_CTL -- requirements
Module: sd_step_ctl

Interface
REQ-001 Parameter width, default 32, monitored channel data width.
REQ-002 Parameter cntw, default 16, step count, remaining and transfer counter width.
REQ-003 Parameter gap, default 6, STEP_WAIT timeout in cycles; legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_srdy  input  1  command valid.
REQ-007 cmd_drdy  output  1  command ready; constant 1 out of reset.
REQ-008 cmd_op  input  2  00 RUN, 01 HALT, 10 STEP, 11 ARM.
REQ-009 cmd_count  input  cntw  STEP transfer count.
REQ-010 cmd_data  input  width  ARM match value.
REQ-011 cmd_mask  input  width  ARM match mask; 1 = bit compared.
REQ-012 mon_srdy, mon_drdy  input  1 each  tap of the stepped channel downstream of the shim.
REQ-013 mon_data  input  width  tapped data.
REQ-014 cfg_en  output  1  shim single-step enable.
REQ-015 cfg_step  output  1  shim step request; the shim acts on its rising edge.
REQ-016 stat_state  output  2  00 RUN, 01 HALT, 10 STEP_HI, 11 STEP_WAIT.
REQ-017 stat_remaining  output  cntw  transfers still to be stepped.
REQ-018 stat_xfer_cnt  output  cntw  total observed transfers.
REQ-019 break_hit  output  1  one-cycle pulse on a break match.
REQ-020 cmd_err  output  1  one-cycle pulse when a command is dropped.

Function
REQ-021 A command is accepted on a cycle with cmd_srdy && cmd_drdy.
REQ-022 An observed transfer is a cycle with mon_srdy && mon_drdy.
REQ-023 stat_xfer_cnt increments by 1 on every observed transfer in every state and wraps from 2^cntw-1 to 0.
REQ-024 cfg_en is registered: 0 in RUN, 1 in HALT, STEP_HI and STEP_WAIT.
REQ-025 cfg_step is registered: 1 only in STEP_HI, otherwise 0.
REQ-026 RUN: HALT -> HALT; STEP with count>0 -> STEP_HI with remaining=count; ARM loads match/mask and sets armed; RUN is a no-op.
REQ-027 RUN: STEP with count 0 -> HALT.
REQ-028 HALT: RUN -> RUN; STEP with count>0 -> STEP_HI with remaining=count; STEP with count 0 is a no-op; ARM loads match/mask and sets armed; HALT is a no-op.
REQ-029 STEP_HI: lasts exactly 2 cycles, then goes to STEP_WAIT with the wait counter loaded with gap.
REQ-030 STEP_WAIT: each observed transfer decrements remaining (saturating at 0), and the wait counter decrements every cycle.
REQ-031 STEP_WAIT exit: when remaining reaches 0 -> HALT; else when the wait counter reaches 0 -> STEP_HI (re-pulse).
REQ-032 In STEP_HI/STEP_WAIT, an accepted HALT -> HALT next cycle and clears remaining.
REQ-033 In STEP_HI/STEP_WAIT, any other accepted op is dropped and pulses cmd_err for 1 cycle.
REQ-034 In STEP_HI, an observed transfer also decrements remaining, and the exit rule of REQ-031 applies after STEP_HI ends.
REQ-035 Break match condition: armed && in RUN && observed transfer && ((mon_data ^ match) & mask) == 0.
REQ-036 On a break match: next state HALT, break_hit pulses 1 cycle, and armed clears.
REQ-037 Break match has priority over a same-cycle accepted command.
REQ-038 Matching is disabled outside RUN.
REQ-039 A same-cycle accepted command and observed transfer are both processed: the transfer counts, then the command applies.

Reset
REQ-040 While rst_n=0 (asynchronously): state RUN, cfg_en=0, cfg_step=0, remaining=0, stat_xfer_cnt=0, armed=0, break_hit=0, cmd_err=0, wait counter=0.
REQ-041 Reset mid-step abandons the step with no further cfg_step edges.
REQ-042 cmd_drdy=1 from the first cycle after rst_n deasserts.

Verification
REQ-043 Reset, then 10 transfers in RUN -> cfg_en=0, stat_xfer_cnt=10, stat_state=00.
REQ-044 HALT, then STEP count=3, with the downstream always ready -> exactly 3 cfg_step rising edges, 3 transfers, final HALT, remaining=0.
REQ-045 STEP count=2 with mon_srdy=0 for 20 cycles, gap=6 -> re-pulse every 8 cycles, remaining stays 2, then completes once traffic resumes.
REQ-046 ARM with data=0x0000_00A5, mask=0x0000_00FF; stream 0x11, 0x22, 0x1A5 -> break_hit on the third transfer, HALT next cycle, armed=0.
REQ-047 STEP count=5 with HALT issued in STEP_WAIT -> HALT, remaining=0; a STEP issued mid-step -> cmd_err pulse, state unchanged.
REQ-048 stat_xfer_cnt preset near 2^16-1 by traffic, then 2 transfers -> wraps to 1; rst_n pulsed low mid STEP_HI -> cfg_step=0 immediately, state RUN.
